// File: rtl/hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage MIPS core: load-use stalls,
// taken-branch flushes, multiply/divide unit issue/busy tracking and a stall counter.
module hazard_ctrl #(
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 32,
  parameter int CNT_W      = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  ID_Rs,
  input  logic [4:0]  ID_Rt,
  input  logic        ID_UsesRs,
  input  logic        ID_UsesRt,
  input  logic        ID_EX_MemRd,
  input  logic [4:0]  ID_EX_Rt,
  input  logic        ID_MdStart,
  input  logic        ID_IsDiv,
  input  logic        ID_MdRead,
  input  logic        EX_BranchTaken,
  output logic        PC_Wr,
  output logic        IF_ID_Wr,
  output logic        IF_ID_Flush,
  output logic        ID_EX_Flush,
  output logic        MD_Start,
  output logic        MD_Busy,
  output logic [31:0] StallCycles
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] busy_cnt_q, busy_cnt_d;
  logic [31:0]      stall_cnt_q, stall_cnt_d;

  logic load_use;
  logic md_hazard;
  logic md_busy;
  logic stall;
  logic md_issue;

  // Register 0 is never a real dependency, so a load into $0 never stalls.
  assign load_use = ID_EX_MemRd && (ID_EX_Rt != 5'd0) &&
                    ((ID_UsesRs && (ID_Rs == ID_EX_Rt)) ||
                     (ID_UsesRt && (ID_Rt == ID_EX_Rt)));

  assign md_busy   = (state_q == BUSY);
  assign md_hazard = (ID_MdStart || ID_MdRead) && md_busy;
  assign stall     = (load_use || md_hazard) && !EX_BranchTaken;

  // A squashed or stalled ID instruction must never start the MDU.
  assign md_issue = (state_q == IDLE) && ID_MdStart && !load_use &&
                    !EX_BranchTaken && !reset;

  assign stall_cnt_d = (stall && (stall_cnt_q != 32'hFFFF_FFFF)) ?
                       stall_cnt_q + 32'd1 : stall_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      busy_cnt_q  <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      busy_cnt_q  <= busy_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Busy counter holds remaining cycles minus one, so BUSY lasts exactly N cycles.
  always_comb begin
    state_d    = state_q;
    busy_cnt_d = busy_cnt_q;
    case (state_q)
      IDLE: begin
        if (md_issue) begin
          state_d    = BUSY;
          busy_cnt_d = ID_IsDiv ? DIV_LOAD : MUL_LOAD;
        end
      end
      BUSY: begin
        if (busy_cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          busy_cnt_d = busy_cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d    = IDLE;
        busy_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    PC_Wr       = 1'b1;
    IF_ID_Wr    = 1'b1;
    IF_ID_Flush = 1'b0;
    ID_EX_Flush = 1'b0;
    MD_Start    = md_issue;
    if (reset) begin
      PC_Wr       = 1'b0;
      IF_ID_Wr    = 1'b0;
      IF_ID_Flush = 1'b1;
      ID_EX_Flush = 1'b1;
    end else if (EX_BranchTaken) begin
      IF_ID_Flush = 1'b1;
      ID_EX_Flush = 1'b1;
    end else if (stall) begin
      PC_Wr       = 1'b0;
      IF_ID_Wr    = 1'b0;
      ID_EX_Flush = 1'b1;
    end
  end

  assign MD_Busy     = md_busy;
  assign StallCycles = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed vectors push hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_hazard_ctrl;

  localparam int MUL_CYCLES = 4;
  localparam int DIV_CYCLES = 32;
  localparam int CNT_W      = 6;

  logic        clk;
  logic        reset;
  logic [4:0]  id_rs, id_rt, id_ex_rt;
  logic        id_uses_rs, id_uses_rt, id_ex_mem_rd;
  logic        id_md_start, id_is_div, id_md_read, ex_branch_taken;
  logic        pc_wr, if_id_wr, if_id_flush, id_ex_flush, md_start, md_busy;
  logic [31:0] stall_cycles;

  typedef struct {
    logic       rst;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rs;
    logic       uses_rt;
    logic       mem_rd;
    logic [4:0] ex_rt;
    logic       md_start;
    logic       is_div;
    logic       md_read;
    logic       branch;
  } stim_t;

  typedef enum {K_RUN, K_STALL, K_BRANCH, K_RESET} kind_t;

  typedef struct {
    logic        pc_wr;
    logic        if_id_wr;
    logic        if_id_flush;
    logic        id_ex_flush;
    logic        md_start;
    logic        md_busy;
    logic [31:0] stalls;
    string       tag;
  } exp_t;

  exp_t        scoreboard[$];
  int          vectors_applied = 0;
  int          miscompares     = 0;
  logic [31:0] exp_stalls      = 32'd0;
  bit          release_pending = 1'b0;

  hazard_ctrl #(
    .MUL_CYCLES(MUL_CYCLES),
    .DIV_CYCLES(DIV_CYCLES),
    .CNT_W     (CNT_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .ID_Rs         (id_rs),
    .ID_Rt         (id_rt),
    .ID_UsesRs     (id_uses_rs),
    .ID_UsesRt     (id_uses_rt),
    .ID_EX_MemRd   (id_ex_mem_rd),
    .ID_EX_Rt      (id_ex_rt),
    .ID_MdStart    (id_md_start),
    .ID_IsDiv      (id_is_div),
    .ID_MdRead     (id_md_read),
    .EX_BranchTaken(ex_branch_taken),
    .PC_Wr         (pc_wr),
    .IF_ID_Wr      (if_id_wr),
    .IF_ID_Flush   (if_id_flush),
    .ID_EX_Flush   (id_ex_flush),
    .MD_Start      (md_start),
    .MD_Busy       (md_busy),
    .StallCycles   (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic stim_t idle_stim();
    stim_t s;
    s = '{rst: 1'b0, rs: 5'd0, rt: 5'd0, uses_rs: 1'b0, uses_rt: 1'b0, mem_rd: 1'b0,
          ex_rt: 5'd0, md_start: 1'b0, is_div: 1'b0, md_read: 1'b0, branch: 1'b0};
    return s;
  endfunction

  function automatic exp_t make_exp(kind_t k, logic mds, logic busy, logic [31:0] stalls,
                                    string tag);
    exp_t e;
    case (k)
      K_RUN:    begin e.pc_wr = 1; e.if_id_wr = 1; e.if_id_flush = 0; e.id_ex_flush = 0; end
      K_STALL:  begin e.pc_wr = 0; e.if_id_wr = 0; e.if_id_flush = 0; e.id_ex_flush = 1; end
      K_BRANCH: begin e.pc_wr = 1; e.if_id_wr = 1; e.if_id_flush = 1; e.id_ex_flush = 1; end
      default:  begin e.pc_wr = 0; e.if_id_wr = 0; e.if_id_flush = 1; e.id_ex_flush = 1; end
    endcase
    e.md_start = mds;
    e.md_busy  = busy;
    e.stalls   = stalls;
    e.tag      = tag;
    return e;
  endfunction

  task automatic drive(input stim_t s);
    reset           = s.rst;
    id_rs           = s.rs;
    id_rt           = s.rt;
    id_uses_rs      = s.uses_rs;
    id_uses_rt      = s.uses_rt;
    id_ex_mem_rd    = s.mem_rd;
    id_ex_rt        = s.ex_rt;
    id_md_start     = s.md_start;
    id_is_div       = s.is_div;
    id_md_read      = s.md_read;
    ex_branch_taken = s.branch;
  endtask

  task automatic applyStimulus(input stim_t s, input exp_t e);
    @(posedge clk);
    #1;
    if (release_pending) begin
      release dut.stall_cnt_d;
      release_pending = 1'b0;
    end
    drive(s);
    scoreboard.push_back(e);
  endtask

  task automatic run_vec(input stim_t s, input logic mds, input logic busy, input string tag);
    applyStimulus(s, make_exp(K_RUN, mds, busy, exp_stalls, tag));
  endtask

  // The count shown during a stall cycle is the pre-stall value.
  task automatic stall_vec(input stim_t s, input logic busy, input string tag);
    applyStimulus(s, make_exp(K_STALL, 1'b0, busy, exp_stalls, tag));
    if (exp_stalls != 32'hFFFF_FFFF) exp_stalls = exp_stalls + 32'd1;
  endtask

  task automatic branch_vec(input stim_t s, input logic busy, input string tag);
    applyStimulus(s, make_exp(K_BRANCH, 1'b0, busy, exp_stalls, tag));
  endtask

  task automatic reset_vec(input stim_t s, input logic busy, input string tag);
    applyStimulus(s, make_exp(K_RESET, 1'b0, busy, exp_stalls, tag));
  endtask

  // Seeds the counter's next value so the following edge loads it near saturation.
  task automatic preload_stalls(input logic [31:0] value);
    @(posedge clk);
    #1;
    drive(idle_stim());
    scoreboard.push_back(make_exp(K_RUN, 1'b0, 1'b0, exp_stalls, "preload"));
    #1;
    force dut.stall_cnt_d = value;
    release_pending = 1'b1;
    exp_stalls = value;
  endtask

  task automatic cmp(input string tag, input string field, input logic [31:0] got,
                     input logic [31:0] want);
    if (got !== want) begin
      miscompares++;
      $display("[TB] FAIL %s.%s: got %h, expected %h", tag, field, got, want);
    end
  endtask

  task automatic checkOutput(input exp_t e);
    vectors_applied++;
    cmp(e.tag, "PC_Wr",       {31'd0, pc_wr},       {31'd0, e.pc_wr});
    cmp(e.tag, "IF_ID_Wr",    {31'd0, if_id_wr},    {31'd0, e.if_id_wr});
    cmp(e.tag, "IF_ID_Flush", {31'd0, if_id_flush}, {31'd0, e.if_id_flush});
    cmp(e.tag, "ID_EX_Flush", {31'd0, id_ex_flush}, {31'd0, e.id_ex_flush});
    cmp(e.tag, "MD_Start",    {31'd0, md_start},    {31'd0, e.md_start});
    cmp(e.tag, "MD_Busy",     {31'd0, md_busy},     {31'd0, e.md_busy});
    cmp(e.tag, "StallCycles", stall_cycles,         e.stalls);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (scoreboard.size() > 0) checkOutput(scoreboard.pop_front());
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    stim_t s;
    s = idle_stim();
    s.rst = 1'b1;
    drive(s);

    reset_vec(s, 1'b0, "reset_hold0");
    reset_vec(s, 1'b0, "reset_hold1");
    exp_stalls = 32'd0;

    s = idle_stim();
    run_vec(s, 1'b0, 1'b0, "idle");

    s = idle_stim(); s.mem_rd = 1; s.ex_rt = 5'd5; s.rs = 5'd5; s.uses_rs = 1;
    stall_vec(s, 1'b0, "lu_rs");
    s = idle_stim();
    run_vec(s, 1'b0, 1'b0, "after_lu");
    s = idle_stim(); s.mem_rd = 1; s.ex_rt = 5'd0; s.rs = 5'd0; s.uses_rs = 1;
    run_vec(s, 1'b0, 1'b0, "lu_r0");
    s = idle_stim(); s.mem_rd = 1; s.ex_rt = 5'd7; s.rt = 5'd7; s.uses_rt = 1;
    stall_vec(s, 1'b0, "lu_rt");
    s.uses_rt = 0;
    run_vec(s, 1'b0, 1'b0, "lu_rt_unused");
    s = idle_stim(); s.ex_rt = 5'd7; s.rs = 5'd7; s.uses_rs = 1;
    run_vec(s, 1'b0, 1'b0, "no_load");

    s = idle_stim(); s.mem_rd = 1; s.ex_rt = 5'd9; s.rs = 5'd9; s.uses_rs = 1; s.branch = 1;
    branch_vec(s, 1'b0, "br_over_lu");
    s = idle_stim();
    run_vec(s, 1'b0, 1'b0, "after_br");
    s = idle_stim(); s.md_start = 1; s.branch = 1;
    branch_vec(s, 1'b0, "br_md_idle");
    s = idle_stim();
    run_vec(s, 1'b0, 1'b0, "br_md_no_issue");

    s = idle_stim(); s.md_start = 1; s.mem_rd = 1; s.ex_rt = 5'd3; s.rs = 5'd3; s.uses_rs = 1;
    stall_vec(s, 1'b0, "lu_blocks_md");
    s = idle_stim();
    run_vec(s, 1'b0, 1'b0, "lu_md_no_issue");

    s = idle_stim(); s.md_start = 1;
    run_vec(s, 1'b1, 1'b0, "mult_issue");
    s = idle_stim(); s.md_read = 1;
    for (int i = 0; i < MUL_CYCLES; i++) stall_vec(s, 1'b1, "mfhi_wait");
    run_vec(s, 1'b0, 1'b0, "mfhi_go");

    s = idle_stim(); s.md_start = 1; s.is_div = 1;
    run_vec(s, 1'b1, 1'b0, "div1_issue");
    for (int i = 0; i < DIV_CYCLES; i++) stall_vec(s, 1'b1, "div2_wait");
    run_vec(s, 1'b1, 1'b0, "div2_issue");
    s = idle_stim();
    for (int i = 0; i < DIV_CYCLES; i++) run_vec(s, 1'b0, 1'b1, "div2_busy");
    run_vec(s, 1'b0, 1'b0, "div2_done");

    s = idle_stim(); s.md_start = 1;
    run_vec(s, 1'b1, 1'b0, "mult_issue2");
    s = idle_stim(); s.branch = 1; s.md_read = 1;
    branch_vec(s, 1'b1, "br_during_busy");
    s = idle_stim();
    for (int i = 0; i < MUL_CYCLES - 1; i++) run_vec(s, 1'b0, 1'b1, "busy_after_br");
    run_vec(s, 1'b0, 1'b0, "mult2_done");

    // Busy counter starts at 31, so the 15th busy cycle holds 17.
    s = idle_stim(); s.md_start = 1; s.is_div = 1;
    run_vec(s, 1'b1, 1'b0, "div3_issue");
    s = idle_stim();
    for (int i = 0; i < 14; i++) run_vec(s, 1'b0, 1'b1, "div3_busy");
    s = idle_stim(); s.rst = 1; s.md_start = 1;
    reset_vec(s, 1'b1, "reset_mid_div");
    exp_stalls = 32'd0;
    s = idle_stim();
    run_vec(s, 1'b0, 1'b0, "post_reset");
    s = idle_stim(); s.md_start = 1;
    run_vec(s, 1'b1, 1'b0, "mult_after_reset");
    s = idle_stim();
    for (int i = 0; i < MUL_CYCLES; i++) run_vec(s, 1'b0, 1'b1, "mult3_busy");
    run_vec(s, 1'b0, 1'b0, "mult3_done");

    preload_stalls(32'hFFFF_FFFE);
    s = idle_stim();
    run_vec(s, 1'b0, 1'b0, "sat_preloaded");
    s = idle_stim(); s.mem_rd = 1; s.ex_rt = 5'd4; s.rt = 5'd4; s.uses_rt = 1;
    applyStimulus(s, make_exp(K_STALL, 1'b0, 1'b0, 32'hFFFF_FFFE, "sat_step"));
    applyStimulus(s, make_exp(K_STALL, 1'b0, 1'b0, 32'hFFFF_FFFF, "sat_hold"));
    s = idle_stim();
    applyStimulus(s, make_exp(K_RUN, 1'b0, 1'b0, 32'hFFFF_FFFF, "sat_final"));

    for (int i = 0; i < 10 && scoreboard.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    if (scoreboard.size() > 0) begin
      miscompares++;
      $display("[TB] FAIL drain: %0d entries left, expected 0", scoreboard.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
